// File: rtl/restoring_divider.sv
// restoring_divider: sequential radix-2 restoring unsigned divider, one quotient bit per cycle
module restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_resp
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q, d, q_nxt;
  logic [WIDTH:0]   r, s, t, r_nxt;
  always_comb begin
    s     = {r[WIDTH-1:0], q[WIDTH-1]};
    t     = s - {1'b0, d};
    r_nxt = t[WIDTH] ? s : t;
    q_nxt = {q[WIDTH-2:0], ~t[WIDTH]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      q         <= '0;
      r         <= '0;
      d         <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_resp  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_resp <= 1'b0;
          if (start) begin
            d     <= denominator;
            q     <= numerator;
            r     <= '0;
            count <= '0;
            // divide by zero resolves immediately with the DIVU/REMU result
            if (denominator == '0) begin
              state     <= DONE;
              quotient  <= '1;
              remainder <= numerator;
              div_resp  <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          q     <= q_nxt;
          r     <= r_nxt;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state     <= DONE;
            quotient  <= q_nxt;
            remainder <= r_nxt[WIDTH-1:0];
            div_resp  <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          div_resp <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
